// File: rtl/magia_pkg.sv
// rtl/magia_pkg.sv - shared AXI channel types, command kinds and default print addresses
package magia_pkg;

    localparam int unsigned AXI_ID_W   = 4;
    localparam int unsigned AXI_ADDR_W = 32;
    localparam int unsigned AXI_DATA_W = 32;
    localparam int unsigned AXI_USER_W = 1;

    localparam logic [31:0] DEFAULT_STDERR_ADDR = 32'hFFFF_0000;
    localparam logic [31:0] DEFAULT_STDOUT_ADDR = 32'hFFFF_0004;
    localparam logic [31:0] DEFAULT_EOC_ADDR    = 32'hCC03_0000;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    typedef enum logic [1:0] {
        CMD_CHAR   = 2'd0,
        CMD_STDERR = 2'd1,
        CMD_EOC    = 2'd2,
        CMD_RSVD   = 2'd3
    } cmd_kind_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_B,
        ST_HALT
    } print_state_e;

    typedef struct packed {
        logic [AXI_ID_W-1:0]   id;
        logic [AXI_ADDR_W-1:0] addr;
        logic [7:0]            len;
        logic [2:0]            size;
        logic [1:0]            burst;
        logic                  lock;
        logic [3:0]            cache;
        logic [2:0]            prot;
        logic [3:0]            qos;
        logic [3:0]            region;
        logic [5:0]            atop;
        logic [AXI_USER_W-1:0] user;
    } axi_aw_chan_t;

    typedef struct packed {
        logic [AXI_DATA_W-1:0]   data;
        logic [AXI_DATA_W/8-1:0] strb;
        logic                    last;
        logic [AXI_USER_W-1:0]   user;
    } axi_w_chan_t;

    typedef struct packed {
        logic [AXI_ID_W-1:0]   id;
        logic [1:0]            resp;
        logic [AXI_USER_W-1:0] user;
    } axi_b_chan_t;

    typedef struct packed {
        logic [AXI_ID_W-1:0]   id;
        logic [AXI_ADDR_W-1:0] addr;
        logic [7:0]            len;
        logic [2:0]            size;
        logic [1:0]            burst;
        logic                  lock;
        logic [3:0]            cache;
        logic [2:0]            prot;
        logic [3:0]            qos;
        logic [3:0]            region;
        logic [AXI_USER_W-1:0] user;
    } axi_ar_chan_t;

    typedef struct packed {
        logic [AXI_ID_W-1:0]   id;
        logic [AXI_DATA_W-1:0] data;
        logic [1:0]            resp;
        logic                  last;
        logic [AXI_USER_W-1:0] user;
    } axi_r_chan_t;

    typedef struct packed {
        axi_aw_chan_t aw;
        logic         aw_valid;
        axi_w_chan_t  w;
        logic         w_valid;
        logic         b_ready;
        axi_ar_chan_t ar;
        logic         ar_valid;
        logic         r_ready;
    } axi_default_req_t;

    typedef struct packed {
        logic        aw_ready;
        logic        ar_ready;
        logic        w_ready;
        logic        b_valid;
        axi_b_chan_t b;
        logic        r_valid;
        axi_r_chan_t r;
    } axi_default_rsp_t;

endpackage

// File: rtl/magia_print_axi_master.sv
// rtl/magia_print_axi_master.sv - single-beat AXI write initiator for stdout chars, stderr counts and EOC
module magia_print_axi_master
    import magia_pkg::*;
#(
    parameter logic [31:0]         STDERR_ADDR = DEFAULT_STDERR_ADDR,
    parameter logic [31:0]         STDOUT_ADDR = DEFAULT_STDOUT_ADDR,
    parameter logic [31:0]         EOC_ADDR    = DEFAULT_EOC_ADDR,
    parameter logic [AXI_ID_W-1:0] AXI_ID      = '0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [1:0]                  cmd_kind,
    input  logic [31:0]                 cmd_data,
    output magia_pkg::axi_default_req_t axi_req_o,
    input  magia_pkg::axi_default_rsp_t axi_rsp_i,
    output logic                        busy,
    output logic                        eoc_done,
    output logic [7:0]                  bresp_err_cnt,
    output logic                        illegal_cmd
);

    print_state_e state;
    logic         cmd_ready_q;
    logic         aw_valid_q;
    logic         w_valid_q;
    logic         b_ready_q;
    logic         busy_q;
    logic         eoc_done_q;
    logic         illegal_q;
    logic         is_eoc_q;
    logic [7:0]   err_cnt_q;
    logic [31:0]  addr_q;
    logic [31:0]  data_q;

    logic         accept;
    logic         start_write;
    logic         start_eoc;
    logic         start_illegal;
    logic [31:0]  start_addr;
    logic [31:0]  start_data;
    logic         aw_ok;
    logic         w_ok;
    logic         unused_rsp;

    assign accept = cmd_valid && cmd_ready_q && (state == ST_IDLE);

    always_comb begin
        start_write   = 1'b0;
        start_eoc     = 1'b0;
        start_illegal = 1'b0;
        start_addr    = STDOUT_ADDR;
        start_data    = {24'b0, cmd_data[7:0]};
        case (cmd_kind_e'(cmd_kind))
            // A NUL character is swallowed rather than printed.
            CMD_CHAR:   start_write = (cmd_data[7:0] != 8'h00);
            CMD_STDERR: begin
                start_write = 1'b1;
                start_addr  = STDERR_ADDR;
                start_data  = cmd_data;
            end
            CMD_EOC: begin
                start_write = 1'b1;
                start_eoc   = 1'b1;
                start_addr  = EOC_ADDR;
                start_data  = cmd_data;
            end
            default:    start_illegal = 1'b1;
        endcase
    end

    // A channel counts as done once its valid has dropped or it handshakes this cycle.
    assign aw_ok = !aw_valid_q || axi_rsp_i.aw_ready;
    assign w_ok  = !w_valid_q  || axi_rsp_i.w_ready;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state       <= ST_IDLE;
            cmd_ready_q <= 1'b1;
            aw_valid_q  <= 1'b0;
            w_valid_q   <= 1'b0;
            b_ready_q   <= 1'b0;
            busy_q      <= 1'b0;
            eoc_done_q  <= 1'b0;
            illegal_q   <= 1'b0;
            is_eoc_q    <= 1'b0;
            err_cnt_q   <= 8'd0;
            addr_q      <= 32'd0;
            data_q      <= 32'd0;
        end else begin
            illegal_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept && start_write) begin
                        addr_q      <= start_addr;
                        data_q      <= start_data;
                        is_eoc_q    <= start_eoc;
                        aw_valid_q  <= 1'b1;
                        w_valid_q   <= 1'b1;
                        busy_q      <= 1'b1;
                        cmd_ready_q <= 1'b0;
                        state       <= ST_SEND;
                    end
                    if (accept && start_illegal) begin
                        illegal_q <= 1'b1;
                    end
                end
                ST_SEND: begin
                    if (aw_valid_q && axi_rsp_i.aw_ready) aw_valid_q <= 1'b0;
                    if (w_valid_q && axi_rsp_i.w_ready)   w_valid_q  <= 1'b0;
                    if (aw_ok && w_ok) begin
                        b_ready_q <= 1'b1;
                        state     <= ST_WAIT_B;
                    end
                end
                ST_WAIT_B: begin
                    if (axi_rsp_i.b_valid) begin
                        b_ready_q <= 1'b0;
                        busy_q    <= 1'b0;
                        if (axi_rsp_i.b.resp != AXI_RESP_OKAY && err_cnt_q != 8'hFF) begin
                            err_cnt_q <= err_cnt_q + 8'd1;
                        end
                        if (is_eoc_q) begin
                            eoc_done_q <= 1'b1;
                            state      <= ST_HALT;
                        end else begin
                            cmd_ready_q <= 1'b1;
                            state       <= ST_IDLE;
                        end
                    end
                end
                ST_HALT: begin
                    state <= ST_HALT;
                end
                default: begin
                    state       <= ST_IDLE;
                    cmd_ready_q <= 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        axi_req_o          = '0;
        axi_req_o.aw.id    = AXI_ID;
        axi_req_o.aw.addr  = addr_q;
        axi_req_o.aw.len   = 8'd0;
        axi_req_o.aw.size  = 3'd2;
        axi_req_o.aw.burst = AXI_BURST_INCR;
        axi_req_o.aw_valid = aw_valid_q;
        axi_req_o.w.data   = data_q;
        axi_req_o.w.strb   = 4'hF;
        axi_req_o.w.last   = 1'b1;
        axi_req_o.w_valid  = w_valid_q;
        axi_req_o.b_ready  = b_ready_q;
    end

    assign unused_rsp    = ^axi_rsp_i;
    assign cmd_ready     = cmd_ready_q;
    assign busy          = busy_q;
    assign eoc_done      = eoc_done_q;
    assign bresp_err_cnt = err_cnt_q;
    assign illegal_cmd   = illegal_q;

endmodule

// File: tb/tb_magia_print_axi_master.sv
// tb/tb_magia_print_axi_master.sv - self-checking bench for magia_print_axi_master
module tb_magia_print_axi_master;
    import magia_pkg::*;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic [1:0]  kind;
        logic [31:0] data;
        logic        exp_wr;
        logic [31:0] exp_addr;
        logic [31:0] exp_data;
        logic        exp_ill;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [1:0]       cmd_kind = 2'd0;
    logic [31:0]      cmd_data = 32'd0;
    axi_default_req_t req;
    axi_default_rsp_t rsp;
    logic             busy;
    logic             eoc_done;
    logic [7:0]       bresp_err_cnt;
    logic             illegal_cmd;

    logic             aw_rdy = 1'b1;
    logic             w_rdy = 1'b1;
    logic             b_hold = 1'b0;
    logic [1:0]       resp_mode = 2'b00;

    logic             b_valid_s = 1'b0;
    logic             b_fire = 1'b0;
    logic             b_pend = 1'b0;
    logic             aw_got = 1'b0;
    logic             w_got = 1'b0;
    logic [31:0]      aw_addr_s = 32'd0;
    logic [31:0]      w_data_s = 32'd0;
    wr_t              obs_q[$];
    wr_t              sb_q[$];
    int               rd_idx = 0;
    int               ill_cnt = 0;
    int               total = 0;
    int               bad = 0;
    vec_t             vecs[7];

    always #5 clk = ~clk;

    magia_print_axi_master dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_kind      (cmd_kind),
        .cmd_data      (cmd_data),
        .axi_req_o     (req),
        .axi_rsp_i     (rsp),
        .busy          (busy),
        .eoc_done      (eoc_done),
        .bresp_err_cnt (bresp_err_cnt),
        .illegal_cmd   (illegal_cmd)
    );

    always_comb begin
        rsp          = '0;
        rsp.aw_ready = aw_rdy;
        rsp.w_ready  = w_rdy;
        rsp.b_valid  = b_valid_s;
        rsp.b.resp   = resp_mode;
    end

    // Slave model: anything valid&ready at the falling edge fires on the next rising edge.
    always @(negedge clk) begin
        if (rst_n) begin
            b_valid_s = 1'b0;
            b_fire    = 1'b0;
            b_pend    = 1'b0;
            aw_got    = 1'b0;
            w_got     = 1'b0;
        end else begin
            if (b_fire) begin
                b_valid_s = 1'b0;
                b_fire    = 1'b0;
            end
            if (req.aw_valid && aw_rdy && !aw_got) begin
                aw_got    = 1'b1;
                aw_addr_s = req.aw.addr;
            end
            if (req.w_valid && w_rdy && !w_got) begin
                w_got    = 1'b1;
                w_data_s = req.w.data;
            end
            if (b_valid_s && req.b_ready) b_fire = 1'b1;
            if (aw_got && w_got) begin
                obs_q.push_back('{aw_addr_s, w_data_s});
                aw_got = 1'b0;
                w_got  = 1'b0;
                b_pend = 1'b1;
            end
            if (b_pend && !b_hold && !b_valid_s) begin
                b_valid_s = 1'b1;
                b_pend    = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (illegal_cmd) ill_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic check_writes();
        wr_t e;
        while (rd_idx < obs_q.size()) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write got=%h/%h exp=none", obs_q[rd_idx].addr, obs_q[rd_idx].data);
            end else begin
                e = sb_q.pop_front();
                chk("wr_addr", obs_q[rd_idx].addr, e.addr);
                chk("wr_data", obs_q[rd_idx].data, e.data);
            end
            rd_idx++;
        end
        chk("missing_writes", 32'(sb_q.size()), 32'd0);
    endtask

    task automatic send_cmd(input logic [1:0] kind, input logic [31:0] data);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_kind  = kind;
        cmd_data  = data;
        for (int i = 0; i < 50 && !cmd_ready; i++) @(negedge clk);
        if (!cmd_ready) chk("accept_timeout", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100 && !(cmd_ready && !busy); i++) @(negedge clk);
        if (!(cmd_ready && !busy)) chk("idle_timeout", 32'(cmd_ready && !busy), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        sb_q.delete();
        rd_idx = obs_q.size();
    endtask

    initial begin
        int w0;
        int i0;

        vecs[0] = '{2'd0, 32'h0000_0041, 1'b1, 32'hFFFF_0004, 32'h0000_0041, 1'b0};
        vecs[1] = '{2'd0, 32'h0000_0000, 1'b0, 32'h0,         32'h0,         1'b0};
        vecs[2] = '{2'd3, 32'h1234_5678, 1'b0, 32'h0,         32'h0,         1'b1};
        vecs[3] = '{2'd1, 32'h0000_0000, 1'b1, 32'hFFFF_0000, 32'h0000_0000, 1'b0};
        vecs[4] = '{2'd0, 32'hABCD_1200, 1'b0, 32'h0,         32'h0,         1'b0};
        vecs[5] = '{2'd0, 32'hFFFF_FF7E, 1'b1, 32'hFFFF_0004, 32'h0000_007E, 1'b0};
        vecs[6] = '{2'd1, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_0000, 32'hFFFF_FFFF, 1'b0};

        do_reset();
        @(negedge clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_eoc_done", 32'(eoc_done), 32'd0);
        chk("rst_err_cnt", 32'(bresp_err_cnt), 32'd0);
        chk("rst_illegal", 32'(illegal_cmd), 32'd0);
        chk("rst_valids", 32'({req.aw_valid, req.w_valid, req.b_ready, req.ar_valid, req.r_ready}), 32'd0);

        foreach (vecs[k]) begin
            w0 = obs_q.size();
            i0 = ill_cnt;
            if (vecs[k].exp_wr) sb_q.push_back('{vecs[k].exp_addr, vecs[k].exp_data});
            send_cmd(vecs[k].kind, vecs[k].data);
            chk("first_send_aw_valid", 32'(req.aw_valid), 32'(vecs[k].exp_wr));
            chk("first_send_w_valid", 32'(req.w_valid), 32'(vecs[k].exp_wr));
            if (vecs[k].exp_wr) begin
                chk("aw_fields", 32'({req.aw.len, req.aw.size, req.aw.burst, req.aw.id}),
                    32'({8'd0, 3'd2, 2'b01, 4'd0}));
                chk("w_fields", 32'({req.w.strb, req.w.last}), 32'({4'hF, 1'b1}));
            end
            wait_idle();
            chk("vec_writes", 32'(obs_q.size() - w0), 32'(vecs[k].exp_wr));
            chk("vec_illegal_pulses", 32'(ill_cnt - i0), 32'(vecs[k].exp_ill));
            chk("vec_err_cnt", 32'(bresp_err_cnt), 32'd0);
            check_writes();
        end

        // W accepted three cycles ahead of AW
        aw_rdy = 1'b0;
        w0 = obs_q.size();
        sb_q.push_back('{32'hFFFF_0000, 32'h0000_0005});
        send_cmd(2'd1, 32'h0000_0005);
        repeat (3) begin
            @(negedge clk);
            chk("wfirst_aw_held", 32'(req.aw_valid), 32'd1);
            chk("wfirst_aw_addr", req.aw.addr, 32'hFFFF_0000);
            chk("wfirst_w_dropped", 32'(req.w_valid), 32'd0);
            chk("wfirst_b_ready", 32'(req.b_ready), 32'd0);
        end
        aw_rdy = 1'b1;
        wait_idle();
        chk("wfirst_writes", 32'(obs_q.size() - w0), 32'd1);
        check_writes();

        // SLVERR saturation
        resp_mode = 2'b10;
        for (int i = 0; i < 300; i++) begin
            sb_q.push_back('{32'hFFFF_0000, 32'(i)});
            send_cmd(2'd1, 32'(i));
            wait_idle();
            if (i == 0) chk("err_cnt_first", 32'(bresp_err_cnt), 32'd1);
        end
        chk("err_cnt_saturated", 32'(bresp_err_cnt), 32'd255);
        check_writes();
        resp_mode = 2'b00;

        // Reset while waiting for B
        b_hold = 1'b1;
        sb_q.push_back('{32'hFFFF_0004, 32'h0000_005A});
        send_cmd(2'd0, 32'h0000_005A);
        repeat (3) @(negedge clk);
        chk("waitb_b_ready", 32'(req.b_ready), 32'd1);
        #2 rst_n = 1'b1;
        #1;
        chk("rst_mid_b_ready", 32'(req.b_ready), 32'd0);
        chk("rst_mid_valids", 32'({req.aw_valid, req.w_valid}), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_err_cnt", 32'(bresp_err_cnt), 32'd0);
        repeat (2) @(negedge clk);
        rst_n  = 1'b0;
        b_hold = 1'b0;
        check_writes();
        w0 = obs_q.size();
        repeat (20) @(negedge clk);
        chk("post_rst_writes", 32'(obs_q.size() - w0), 32'd0);
        chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("post_rst_b_ready", 32'(req.b_ready), 32'd0);

        // EOC then terminal HALT
        w0 = obs_q.size();
        sb_q.push_back('{32'hCC03_0000, 32'h0000_DEAD});
        send_cmd(2'd2, 32'h0000_DEAD);
        for (int i = 0; i < 100 && !eoc_done; i++) @(negedge clk);
        chk("eoc_done", 32'(eoc_done), 32'd1);
        chk("eoc_busy", 32'(busy), 32'd0);
        cmd_valid = 1'b1;
        cmd_kind  = 2'd0;
        cmd_data  = 32'h0000_0041;
        repeat (10) begin
            @(negedge clk);
            chk("halt_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        cmd_valid = 1'b0;
        chk("eoc_writes", 32'(obs_q.size() - w0), 32'd1);
        check_writes();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/magia_print_axi_master.md
MAGIA_PRINT_AXI_MASTER -- requirements
Module: magia_print_axi_master

Interface
REQ-001 SHALL have parameter STDERR_ADDR, 32'hFFFF_0000, target address for error-count writes.
REQ-002 SHALL have parameter STDOUT_ADDR, 32'hFFFF_0004, target address for character writes.
REQ-003 SHALL have parameter EOC_ADDR, 32'hCC03_0000, target address for the end-of-computation exit code.
REQ-004 SHALL have parameter AXI_ID, 0, AXI ID driven on every AW.
REQ-005 SHALL have port clk  input  1  clock.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port cmd_valid  input  1  command offered.
REQ-008 SHALL have port cmd_ready  output  1  command accepted when high together with cmd_valid.
REQ-009 SHALL have port cmd_kind  input  2  0=char, 1=stderr count, 2=EOC, 3=reserved.
REQ-010 SHALL have port cmd_data  input  32  payload.
REQ-011 SHALL have port axi_req_o  output  magia_pkg::axi_default_req_t  AXI initiator request.
REQ-012 SHALL have port axi_rsp_i  input  magia_pkg::axi_default_rsp_t  AXI initiator response.
REQ-013 SHALL have port busy  output  1  transaction in flight.
REQ-014 SHALL have port eoc_done  output  1  sticky; EOC write completed.
REQ-015 SHALL have port bresp_err_cnt  output  8  saturating count of B responses with non-OKAY resp.
REQ-016 SHALL have port illegal_cmd  output  1  one-cycle pulse when a reserved kind is accepted.

Function
REQ-017 SHALL implement FSM states IDLE, SEND, WAIT_B, HALT.
REQ-018 SHALL drive cmd_ready=1 only in IDLE.
REQ-019 SHALL, on IDLE accept with kind 0..2, latch address (char->STDOUT_ADDR, count->STDERR_ADDR, EOC->EOC_ADDR) and data, and enter SEND.
REQ-020 SHALL zero-extend char payload from cmd_data[7:0]; a char with byte 0 SHALL be accepted and dropped, staying in IDLE.
REQ-021 SHALL write stderr count and EOC payloads as full 32-bit values, including 0.
REQ-022 SHALL, for reserved kind, accept, drop, pulse illegal_cmd the next cycle and stay in IDLE.
REQ-023 SHALL assert aw_valid and w_valid in the first SEND cycle, i.e. one cycle after acceptance.
REQ-024 SHALL hold each valid and its payload stable until its own ready; AW and W handshakes complete independently, in either order or in the same cycle.
REQ-025 SHALL move SEND->WAIT_B in the cycle after both AW and W have handshaken; b_ready=1 only in WAIT_B.
REQ-026 SHALL, on b_valid in WAIT_B, increment bresp_err_cnt (saturating at 255) if resp!=OKAY, then go to HALT for an EOC transaction, otherwise to IDLE.
REQ-027 SHALL drive AW with len=0, size=2, burst=INCR, id=AXI_ID, all other fields 0; W with strb=4'hF, last=1.
REQ-028 SHALL keep ar_valid=0 and r_ready=0 permanently.
REQ-029 SHALL set eoc_done on entry to HALT; HALT is terminal until reset, with cmd_ready=0.
REQ-030 SHALL drive busy=1 in SEND and WAIT_B.
REQ-031 SHALL limit outstanding transactions to one; there is no command buffering.

Reset
REQ-032 SHALL, with rst_n high, asynchronously enter IDLE and clear all valids, b_ready, busy, eoc_done, illegal_cmd and bresp_err_cnt; cmd_ready=1 after release.
REQ-033 SHALL abandon an in-flight transaction on reset mid-operation, with no retry after release.

Structure
REQ-034 SHALL place the cmd_kind enum and default address constants in magia_pkg.
REQ-035 SHALL be a single module with no sub-modules; AXI types come from magia_pkg.

Verification
REQ-036 SHALL test char 'A' (0x41), slave AW/W ready=1, B OKAY next cycle: AW addr 0xFFFF_0004, W data 0x0000_0041, back to IDLE, counter 0.
REQ-037 SHALL test char 0x00 and kind 3: no AW/W issued; illegal_cmd pulses once, for kind 3 only.
REQ-038 SHALL test W ready 3 cycles before AW ready on stderr count 5: W completes first, valids held stable, single write 0x5 to 0xFFFF_0000.
REQ-039 SHALL test B resp SLVERR on 300 consecutive writes: bresp_err_cnt saturates at 255.
REQ-040 SHALL test EOC code 0xDEAD: write to 0xCC03_0000, eoc_done=1, cmd_ready stays 0 despite further cmd_valid.
REQ-041 SHALL test rst_n asserted during WAIT_B: b_ready and all valids drop immediately, IDLE after release, no further AXI activity.
